// File: rtl/display_timing_gen.sv
// display_timing_gen: free-running raster timing master for the video path.
//
// Produces the pixel coordinate (o_x, o_y), the stage-0 timing flags
// (o_de, o_v_sync, o_frame_start) consumed by the graphics mixer, and a
// one-clock pixel stage that registers and blanks the mixer's RGB result and
// drives it to the display pins with hsync/vsync/de realigned to it.
//
// Ports:
//   i_clk          pixel clock
//   i_rst          synchronous, active-high reset
//   o_x, o_y       current horizontal / vertical count (zero-extended)
//   o_v_sync       vertical sync, aligned with o_x/o_y
//   o_de           active-area flag, aligned with o_x/o_y
//   o_frame_start  one-clock pulse at (0,0)
//   i_red/green/blue  mixer colour for the current o_x/o_y
//   o_vga_*        registered, blanked colour plus hs/vs/de, one clock later
module display_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic [15:0] o_x,
  output logic [15:0] o_y,
  output logic        o_v_sync,
  output logic        o_de,
  output logic        o_frame_start,
  input  logic [7:0]  i_red,
  input  logic [7:0]  i_green,
  input  logic [7:0]  i_blue,
  output logic [7:0]  o_vga_red,
  output logic [7:0]  o_vga_green,
  output logic [7:0]  o_vga_blue,
  output logic        o_vga_hs,
  output logic        o_vga_vs,
  output logic        o_vga_de
);

  localparam int unsigned CW      = 16;
  localparam int unsigned CLRW    = 8;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Counter-width copies of the timing boundaries so every compare is CW wide.
  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_END  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_END  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] H_SYN_BEG  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SYN_END  = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_SYN_BEG  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_SYN_END  = CW'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic SYNC_ON  = SYNC_POL;
  localparam logic SYNC_OFF = ~SYNC_POL;

  // h_cnt/v_cnt hold the position that will be presented on the next edge;
  // the registered outputs therefore show (0,0) on the first edge after reset.
  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;
  logic          hs_q;

  logic          h_wrap_c;
  logic          v_wrap_c;
  logic [CW-1:0] h_next_c;
  logic [CW-1:0] v_next_c;
  logic          de_c;
  logic          hs_c;
  logic          vs_c;
  logic          fs_c;

  // Next-position arithmetic and stage-0 decode of the position being presented.
  always_comb begin
    h_wrap_c = (h_cnt == H_LAST);
    v_wrap_c = (v_cnt == V_LAST);
    h_next_c = h_wrap_c ? '0 : h_cnt + CW'(1);
    v_next_c = v_cnt;
    if (h_wrap_c) begin
      v_next_c = v_wrap_c ? '0 : v_cnt + CW'(1);
    end
    de_c = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
    hs_c = ((h_cnt >= H_SYN_BEG) && (h_cnt < H_SYN_END)) ? SYNC_ON : SYNC_OFF;
    vs_c = ((v_cnt >= V_SYN_BEG) && (v_cnt < V_SYN_END)) ? SYNC_ON : SYNC_OFF;
    fs_c = (h_cnt == '0) && (v_cnt == '0);
  end

  // Stage 0: raster counters and timing flags for the mixer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      h_cnt         <= '0;
      v_cnt         <= '0;
      o_x           <= '0;
      o_y           <= '0;
      o_de          <= 1'b0;
      o_v_sync      <= SYNC_OFF;
      o_frame_start <= 1'b0;
      hs_q          <= SYNC_OFF;
    end else begin
      h_cnt         <= h_next_c;
      v_cnt         <= v_next_c;
      o_x           <= h_cnt;
      o_y           <= v_cnt;
      o_de          <= de_c;
      o_v_sync      <= vs_c;
      o_frame_start <= fs_c;
      hs_q          <= hs_c;
    end
  end

  // Stage 1: capture mixer colour for the stage-0 position, blank outside the
  // active area, and delay the syncs/de by the same single clock.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_vga_red   <= '0;
      o_vga_green <= '0;
      o_vga_blue  <= '0;
      o_vga_hs    <= SYNC_OFF;
      o_vga_vs    <= SYNC_OFF;
      o_vga_de    <= 1'b0;
    end else begin
      o_vga_red   <= o_de ? i_red   : CLRW'(0);
      o_vga_green <= o_de ? i_green : CLRW'(0);
      o_vga_blue  <= o_de ? i_blue  : CLRW'(0);
      o_vga_hs    <= hs_q;
      o_vga_vs    <= o_v_sync;
      o_vga_de    <= o_de;
    end
  end

endmodule

// File: tb/tb_display_timing_gen.sv
// Randomized-reset bench for display_timing_gen: a small-parameter instance
// checked every clock against a position-arithmetic model, plus a
// default-parameter instance checked over its first few lines.
module tb_display_timing_gen;

  localparam int HA = 4, HF = 1, HSW = 2, HB = 1;
  localparam int VA = 3, VF = 1, VSW = 1, VB = 1;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;
  localparam bit SP = 1'b0;
  localparam int NCYC = 3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rst_d;
  logic [7:0]  i_red, i_green, i_blue;

  logic [15:0] x, y;
  logic        vsync, de, fs, vhs, vvs, vde;
  logic [7:0]  vr, vg, vb;

  logic [15:0] dx, dy;
  logic        dvsync, dde, dfs, dvhs, dvvs, dvde;
  logic [7:0]  dvr, dvg, dvb;

  display_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .SYNC_POL(SP)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .o_x(x), .o_y(y), .o_v_sync(vsync), .o_de(de), .o_frame_start(fs),
    .i_red(i_red), .i_green(i_green), .i_blue(i_blue),
    .o_vga_red(vr), .o_vga_green(vg), .o_vga_blue(vb),
    .o_vga_hs(vhs), .o_vga_vs(vvs), .o_vga_de(vde)
  );

  display_timing_gen dut_d (
    .i_clk(clk), .i_rst(rst_d),
    .o_x(dx), .o_y(dy), .o_v_sync(dvsync), .o_de(dde), .o_frame_start(dfs),
    .i_red(i_red), .i_green(i_green), .i_blue(i_blue),
    .o_vga_red(dvr), .o_vga_green(dvg), .o_vga_blue(dvb),
    .o_vga_hs(dvhs), .o_vga_vs(dvvs), .o_vga_de(dvde)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Position k (clocks since reset release) -> expected stage-0 timing.
  task automatic stage0(input int k, input int ha, hf, hsw, hb, va, vf, vsw, vb,
                        output int ox, oy, output logic ode, ohs, ovs, ofs);
    int ht = ha + hf + hsw + hb;
    int vt = va + vf + vsw + vb;
    ox  = k % ht;
    oy  = (k / ht) % vt;
    ode = (ox < ha) && (oy < va);
    ohs = (ox >= ha + hf && ox < ha + hf + hsw) ? SP : ~SP;
    ovs = (oy >= va + vf && oy < va + vf + vsw) ? SP : ~SP;
    ofs = (ox == 0) && (oy == 0);
  endtask

  // Small-instance model state
  bit         in_rst;
  int         k, ex, ey;
  logic       ede, ehs, evs, efs, evhs, evvs, evde;
  logic [7:0] evr, evg, evb;

  // Default-instance model state
  bit         d_in_rst;
  int         dk, dex, dey;
  logic       dede, dehs, devs, defs, devhs;

  int         rst_left, last_fs, cyc_fs;
  bit         dir_done, rst_since_fs;
  logic [31:0] key;

  initial begin
    rst = 1'b1; rst_d = 1'b1;
    i_red = '0; i_green = '0; i_blue = '0;
    in_rst = 1'b1; k = 0; ex = 0; ey = 0;
    ede = 1'b0; ehs = ~SP; evs = ~SP; efs = 1'b0;
    evhs = ~SP; evvs = ~SP; evde = 1'b0; evr = '0; evg = '0; evb = '0;
    d_in_rst = 1'b1; dk = 0; dex = 0; dey = 0;
    dede = 1'b0; dehs = ~SP; devs = ~SP; defs = 1'b0; devhs = ~SP;
    rst_left = 0; last_fs = -1; dir_done = 1'b0; rst_since_fs = 1'b0;
    key = $urandom;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      // Stimulus for the coming edge: reset schedule and mixer colour.
      if (cyc < 10) rst = 1'b1;
      else if (rst_left > 0) begin rst = 1'b1; rst_left--; end
      else if (!dir_done && !in_rst && k >= HT * VT && ex == 3 && ey == 2) begin
        rst = 1'b1; dir_done = 1'b1;
      end
      else if (cyc > 200 && $urandom_range(0, 299) == 0) begin
        rst = 1'b1; rst_left = $urandom_range(0, 3);
      end
      else rst = 1'b0;
      rst_d = (cyc < 10);
      if (rst) rst_since_fs = 1'b1;
      if (in_rst) key = $urandom;
      i_red   = 8'(ex) ^ key[7:0];
      i_green = 8'hAA;
      i_blue  = 8'(ey) ^ key[23:16];

      @(posedge clk);
      if (rst) begin
        in_rst = 1'b1; ex = 0; ey = 0;
        ede = 1'b0; ehs = ~SP; evs = ~SP; efs = 1'b0;
        evhs = ~SP; evvs = ~SP; evde = 1'b0; evr = '0; evg = '0; evb = '0;
      end else begin
        evr  = ede ? i_red   : 8'h00;
        evg  = ede ? i_green : 8'h00;
        evb  = ede ? i_blue  : 8'h00;
        evhs = ehs; evvs = evs; evde = ede;
        k = in_rst ? 0 : k + 1;
        in_rst = 1'b0;
        stage0(k, HA, HF, HSW, HB, VA, VF, VSW, VB, ex, ey, ede, ehs, evs, efs);
      end
      if (rst_d) begin
        d_in_rst = 1'b1; dex = 0; dey = 0;
        dede = 1'b0; dehs = ~SP; devs = ~SP; defs = 1'b0; devhs = ~SP;
      end else begin
        devhs = dehs;
        dk = d_in_rst ? 0 : dk + 1;
        d_in_rst = 1'b0;
        stage0(dk, 640, 16, 96, 48, 480, 10, 2, 33, dex, dey, dede, dehs, devs, defs);
      end

      @(negedge clk);
      check("x", 32'(x), 32'(ex));
      check("y", 32'(y), 32'(ey));
      check("de", 32'(de), 32'(ede));
      check("v_sync", 32'(vsync), 32'(evs));
      check("frame_start", 32'(fs), 32'(efs));
      check("vga_red", 32'(vr), 32'(evr));
      check("vga_green", 32'(vg), 32'(evg));
      check("vga_blue", 32'(vb), 32'(evb));
      check("vga_hs", 32'(vhs), 32'(evhs));
      check("vga_vs", 32'(vvs), 32'(evvs));
      check("vga_de", 32'(vde), 32'(evde));

      // Frame-start spacing when no reset intervened.
      if (fs === 1'b1) begin
        cyc_fs = cyc;
        if (last_fs >= 0 && !rst_since_fs) check("fs_period", 32'(cyc_fs - last_fs), 32'(HT * VT));
        last_fs = cyc_fs;
        rst_since_fs = 1'b0;
      end

      check("d_x", 32'(dx), 32'(dex));
      check("d_y", 32'(dy), 32'(dey));
      check("d_de", 32'(dde), 32'(dede));
      check("d_v_sync", 32'(dvsync), 32'(devs));
      check("d_frame_start", 32'(dfs), 32'(defs));
      check("d_vga_hs", 32'(dvhs), 32'(devhs));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/display_timing_gen.md
Name: display_timing_gen

Overview:
Raster timing master for the video path. It produces the pixel coordinates and vertical sync that the graphics mixer consumes. The mixer's RGB result is taken back, registered and blanked, then driven to the display pins with sync and data-enable realigned to it. It is the only source of i_x/i_y/i_v_sync for the whole graphics pipeline.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, asserted level of both syncs (0 = active-low)

Ports:
i_clk  in  1  pixel clock
i_rst  in  1  reset, synchronous, active-high
o_x  out  16  current horizontal count, 0..H_TOTAL-1
o_y  out  16  current vertical count, 0..V_TOTAL-1
o_v_sync  out  1  vertical sync to mixer/sprites, aligned with o_x/o_y
o_de  out  1  active-area flag, aligned with o_x/o_y
o_frame_start  out  1  one-clock pulse when (o_x,o_y)=(0,0)
i_red  in  8  mixer red for the current o_x/o_y
i_green  in  8  mixer green
i_blue  in  8  mixer blue
o_vga_red  out  8  registered, blanked red
o_vga_green  out  8  registered, blanked green
o_vga_blue  out  8  registered, blanked blue
o_vga_hs  out  1  horizontal sync, aligned with o_vga_*
o_vga_vs  out  1  vertical sync, aligned with o_vga_*
o_vga_de  out  1  data enable, aligned with o_vga_*

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Counters: h increments every clock and wraps H_TOTAL-1 -> 0. v increments only on h wrap, and wraps V_TOTAL-1 -> 0 on the same clock that h wraps.
- o_x=h, o_y=v, zero-extended to 16 bits. All timing outputs are registered and mutually aligned to the same (h,v).
- o_de = (h < H_ACTIVE) && (v < V_ACTIVE).
- hsync asserted (level SYNC_POL) for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
- vsync asserted for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), for whole lines, starting at h=0 of the first sync line.
- o_v_sync = vsync at stage 0. o_frame_start = 1 only at h=0, v=0.
- Reset, while i_rst=1: h=v=0, o_x=o_y=0, o_de=0, o_frame_start=0, o_v_sync/o_vga_hs/o_vga_vs = inactive (~SYNC_POL), o_vga_red/o_vga_green/o_vga_blue=0, o_vga_de=0.
- First clock after i_rst falls: outputs show (0,0), o_de=1, o_frame_start=1.
- Reset asserted mid-frame: on the next edge, state returns to the reset values above. No partial-line completion.
- Pixel stage, fixed latency of 1 clock:
  - On each edge, o_vga_* = i_* if o_de was 1, else 0.
  - o_vga_hs, o_vga_vs, o_vga_de = stage-0 hsync, vsync, de delayed 1 clock.
  - i_* must be a combinational function of o_x/o_y within the same cycle.
- No backpressure. Timing runs free and is never stalled.

Test Plan:
- Small params (H 4/1/2/1 -> H_TOTAL 8; V 3/1/1/1 -> V_TOTAL 6, SYNC_POL 0), release reset -> o_x sequence 0..7,0; o_y steps 0->1 when o_x goes 7->0; o_frame_start=1 every 48 clocks, only at (0,0).
- Same params -> o_de=1 exactly for x<4 && y<3 (12 clocks/frame). hs=0 only at x=5,6. o_v_sync=0 for all 8 clocks of y=4.
- Default params -> hs low for h=656..751; vs low for v=490..491; frame period 800*525 = 420000 clocks.
- Drive i_red=i_x[7:0], i_green=0xAA, i_blue=i_y[7:0] -> one clock later o_vga_red equals the previous o_x; o_vga_* = 0 whenever o_vga_de=0; o_vga_hs matches hs delayed by 1.
- Assert i_rst for 1 clock at (x=3,y=2) -> next clock all outputs at reset values. The clock after release shows (0,0), o_frame_start=1.
- Hold i_rst high 10 clocks -> counters stay 0, o_de=0, o_vga_red/o_vga_green/o_vga_blue=0, syncs stay high (inactive).
